// File: rtl/vga_sprite_memory_loader.sv
// Sprite RAM write-side loader: takes a raster-order pixel stream over a
// valid/ready handshake and writes it to a Size x Size sprite RAM.
// Ports:
//   Clk, Reset                 rising-edge clock, async active-high reset
//   Start, Abort               begin a load (IDLE only), cancel a load
//   Pixel, PixelValid          incoming pixel beat
//   PixelReady                 beat acceptance (LOAD and no Abort)
//   WrEn, WrAddr, WrData       registered sprite RAM write port
//   Row, Col                   position of the next pixel to accept
//   Busy, Done                 LOAD indicator, last-write pulse
module vga_sprite_memory_loader #(
    parameter int N    = 8,
    parameter int Size = 16,
    parameter int W    = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Abort,
    input  logic [W-1:0] Pixel,
    input  logic         PixelValid,
    output logic         PixelReady,
    output logic         WrEn,
    output logic [N-1:0] WrAddr,
    output logic [W-1:0] WrData,
    output logic [9:0]   Row,
    output logic [9:0]   Col,
    output logic         Busy,
    output logic         Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [9:0]   row_q, row_d;
    logic [9:0]   col_q, col_d;
    logic         wren_q, wren_d;
    logic [N-1:0] wraddr_q, wraddr_d;
    logic [W-1:0] wrdata_q, wrdata_d;

    logic         ready;
    logic         accept;
    logic         col_last;
    logic         row_last;
    logic [19:0]  addr_full;
    logic         unused_addr_hi;

    // Same Row*Size+Col mapping as the display read path, kept wide so
    // the product never overflows before truncation to N bits.
    assign addr_full = 20'(row_q) * 20'(Size) + 20'(col_q);
    assign unused_addr_hi = ^addr_full[19:N];

    assign col_last = (col_q == 10'(Size - 1));
    assign row_last = (row_q == 10'(Size - 1));

    // Abort gates ready combinationally so a beat offered alongside
    // Abort is never consumed.
    assign ready  = (state_q == LOAD) && !Abort;
    assign accept = ready && PixelValid;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        wren_d   = accept;
        wraddr_d = wraddr_q;
        wrdata_d = wrdata_q;

        if (accept) begin
            wraddr_d = addr_full[N-1:0];
            wrdata_d = Pixel;
        end

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = LOAD;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            LOAD: begin
                if (Abort) begin
                    state_d = IDLE;
                    row_d   = '0;
                    col_d   = '0;
                end else if (accept) begin
                    if (col_last) begin
                        col_d = '0;
                        if (row_last) begin
                            row_d   = '0;
                            state_d = DONE;
                        end else begin
                            row_d = row_q + 10'd1;
                        end
                    end else begin
                        col_d = col_q + 10'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            wren_q   <= 1'b0;
            wraddr_q <= '0;
            wrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            wren_q   <= wren_d;
            wraddr_q <= wraddr_d;
            wrdata_q <= wrdata_d;
        end
    end

    assign PixelReady = ready;
    assign WrEn       = wren_q;
    assign WrAddr     = wraddr_q;
    assign WrData     = wrdata_q;
    assign Row        = row_q;
    assign Col        = col_q;
    assign Busy       = (state_q == LOAD);
    // DONE is entered on the last accept, so it lines up with the
    // registered write of the final pixel.
    assign Done       = (state_q == DONE);

endmodule
